// File: rtl/uart_pkg.sv
// Shared types and constants for the processor-side I/O port bus.
package uart_pkg;

    localparam int unsigned PORT_ADDR_W  = 16;
    localparam int unsigned PORT_DATA_W  = 8;
    localparam int unsigned IO_SPACE_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_t;

endpackage

// File: rtl/rr_select2.sv
// Two-requester round-robin winner select; the requester not granted last wins a tie.
module rr_select2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       win_c,
    output logic       any_c
);

    always_comb begin
        any_c = |req;
        if (req == 2'b11) begin
            win_c = ~last_gnt;
        end else begin
            win_c = req[1];
        end
    end

endmodule

// File: rtl/port_bus_arbiter.sv
// Round-robin sequencer sharing the 16-bit I/O port bus between two requesters;
// each grant runs SETUP -> STROBE -> DONE, out-of-space addresses skip the strobe.
module port_bus_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W = PORT_ADDR_W,
    parameter int unsigned DATA_W = PORT_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] port_ID,
    output logic [DATA_W-1:0] out_port,
    output logic              write_strobe,
    output logic              read_strobe,
    input  logic [DATA_W-1:0] in_port
);

    bus_state_t        state, state_d;
    logic [1:0]        gnt_d, done_d;
    logic              err_d, ws_d, rs_d;
    logic              we_l, we_l_d;
    logic              last_gnt, last_gnt_d;
    logic [ADDR_W-1:0] port_id_d;
    logic [DATA_W-1:0] out_port_d, rdata_d;
    logic              win_c, any_c;

    rr_select2 u_sel (
        .req      (req),
        .last_gnt (last_gnt),
        .win_c    (win_c),
        .any_c    (any_c)
    );

    // All outputs are the registered image of the next-state logic below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            gnt          <= '0;
            done         <= '0;
            err          <= 1'b0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            we_l         <= 1'b0;
            last_gnt     <= 1'b1;
            port_ID      <= '0;
            out_port     <= '0;
            rdata        <= '0;
        end else begin
            state        <= state_d;
            gnt          <= gnt_d;
            done         <= done_d;
            err          <= err_d;
            write_strobe <= ws_d;
            read_strobe  <= rs_d;
            we_l         <= we_l_d;
            last_gnt     <= last_gnt_d;
            port_ID      <= port_id_d;
            out_port     <= out_port_d;
            rdata        <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        done_d     = '0;
        err_d      = 1'b0;
        ws_d       = 1'b0;
        rs_d       = 1'b0;
        we_l_d     = we_l;
        last_gnt_d = last_gnt;
        port_id_d  = port_ID;
        out_port_d = out_port;
        rdata_d    = rdata;

        case (state)
            ST_IDLE: begin
                if (any_c) begin
                    gnt_d      = win_c ? 2'b10 : 2'b01;
                    we_l_d     = we[win_c];
                    port_id_d  = win_c ? addr1 : addr0;
                    out_port_d = win_c ? wdata1 : wdata0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Top address bit marks space the decoder does not own.
                if (port_ID[ADDR_W-1]) begin
                    done_d  = gnt;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ws_d    = we_l;
                    rs_d    = ~we_l;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (read_strobe) begin
                    rdata_d = in_port;
                end
                done_d  = gnt;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_gnt_d = gnt[1];
                gnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/port_bus_arbiter.md
# port_bus_arbiter

Sequencing controller for the processor-side 16-bit I/O port bus that feeds the UART address decoder. It shares that bus between two requesters: requester 0 is the processor I/O shim and requester 1 is the configuration/debug loader. Each accepted request becomes one well-formed bus transaction: address and data set up one cycle ahead, then a single-cycle `write_strobe` or `read_strobe`, then read data capture. Arbitration is round-robin, and requests outside the decoder's address space are rejected without a strobe.

## Interface
- `ADDR_W`, 16: port address width; bit `ADDR_W-1` set means outside the decoded I/O space.
- `DATA_W`, 8: port data width.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `req[1:0]` in 2: per-requester request, held until its `done` pulse.
- `we[1:0]` in 2: per-requester direction, 1 = write, 0 = read.
- `addr0`, `addr1` in ADDR_W: per-requester port address.
- `wdata0`, `wdata1` in DATA_W: per-requester write data.
- `gnt[1:0]` out 2: one-hot grant, high from SETUP through DONE.
- `done[1:0]` out 2: one-cycle completion pulse to the granted requester.
- `err` out 1: qualifies `done`; high means rejected, out-of-space address.
- `rdata` out DATA_W: captured read data, valid with `done`, held until the next read completes.
- `port_ID` out ADDR_W: bus address to the decoder.
- `out_port` out DATA_W: bus write data.
- `write_strobe` out 1: one-cycle write strobe.
- `read_strobe` out 1: one-cycle read strobe.
- `in_port` in DATA_W: muxed read data from peripherals, valid during the `read_strobe` cycle.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: if any `req` is high, select a winner.
  - One requester: that requester wins.
  - Both requesters: the one that is not `last_gnt` wins.
  - Register the winner's `we`, `addr` and `wdata` into the bus registers, set `gnt`, go to SETUP.
- SETUP: `port_ID` and `out_port` are driven and both strobes stay low.
  - `port_ID[ADDR_W-1]` = 1: go to DONE with `err` pending and no strobe.
  - Otherwise: go to STROBE.
- STROBE: exactly one strobe is high for one cycle, per the latched `we`. On a read, `in_port` is sampled into `rdata` at the clock edge that ends STROBE. Go to DONE.
- DONE: pulse `done[g]` for the granted requester, with `err` if it is a rejection. Update `last_gnt` = g, clear `gnt`, go to IDLE.
- Request fields are latched in IDLE. Changes on `addr`/`wdata`/`we`/`req` during a transaction have no effect. A requester that drops `req` mid-transaction still gets the transaction completed, and its `done` is issued regardless.
- `port_ID`/`out_port` hold their last values in IDLE; the decoder is gated by the strobes.
- `rdata` is unchanged by writes and by rejected reads.
- The strobes are never both high, and never high outside STROBE.

## Timing
- Reset values: state IDLE, `gnt`=0, `done`=0, `err`=0, `rdata`=0, `port_ID`=0, `out_port`=0, `write_strobe`=0, `read_strobe`=0, `last_gnt`=1 so requester 0 wins the first tie.
- Reset is asynchronous: assertion mid-transaction drops the strobes, `gnt` and `done` immediately; the aborted transaction is not reported.
- All outputs are registered; nothing is combinational from inputs to outputs.
- Request seen at edge N (IDLE):
  - `gnt` and bus valid from N+1.
  - Strobe high during cycle N+2.
  - `done` (and `rdata` for reads) during cycle N+3.
  - IDLE at N+4.
- Rejected request: `done`+`err` at N+2, IDLE at N+3.
- Back-to-back: one transaction per 4 cycles. A continuously asserted pair of requesters alternates 0,1,0,1.
- `err` is 0 whenever `done` is 0.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE/SETUP/STROBE/DONE).
  - `PORT_ADDR_W`=16, `PORT_DATA_W`=8.
  - `IO_SPACE_BIT`=15.
- One sub-module `rr_select2`: two-request round-robin winner select from `req` and `last_gnt`. It is combinational and instantiated once.
- The FSM and the bus/capture registers live in the top module.

## Test plan
- Write: requester 0 writes `addr0`=16'h0003, `wdata0`=8'hA5 → `port_ID`=16'h0003 and `out_port`=8'hA5 at N+1, `write_strobe` high only at N+2, `done[0]` at N+3, `err`=0.
- Read: requester 1 reads 16'h0002 while `in_port`=8'h3C in the strobe cycle → `read_strobe` high only at N+2, `rdata`=8'h3C with `done[1]` at N+3, `rdata` still 8'h3C after a later write.
- Tie and fairness: both `req` high continuously from reset → grant order 0,1,0,1, one `done` every 4 cycles, no cycle with both strobes high.
- Rejection: requester 0 reads 16'h8001 → no strobe, `done[0]` and `err` at N+2, `rdata` unchanged.
- Mid-transaction changes: `req[0]` drops and `addr0` changes to 16'h0007 during SETUP → strobe still issued to the originally latched address, `done[0]` still pulses.
- Reset mid-op: `reset_n` low during STROBE → `write_strobe` low within the same cycle, all outputs at reset values, no `done`; after release, a pending `req[1]` is granted normally.
